// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 4;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, and keep or restore the partial remainder.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // When the trial subtraction does not borrow, the true difference is below
  // the divisor, so the low WIDTH bits of the subtraction are exact.
  always_comb begin
    shifted  = {rem, bit_in};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional zero-divisor fast path enabled by RESTORING_DIVIDER_DIVZ_EN.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic               accept;

  // dvd_q shifts dividend bits out of its MSB while quotient bits enter its LSB.
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dvs),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

`ifdef RESTORING_DIVIDER_DIVZ_EN
  logic divz_pending;

  // The DONE->IDLE edge doubles as an accept edge, giving one division per
  // WIDTH+1 cycles; the first DONE cycle of a zero-divisor op cannot accept.
  always_comb begin
    accept = start && ((state == IDLE) || ((state == DONE) && !divz_pending));
  end
`else
  always_comb begin
    accept = start && ((state == IDLE) || (state == DONE));
  end

  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dvd_q     <= '0;
      dvs       <= '0;
      rem       <= '0;
      count     <= '0;
`ifdef RESTORING_DIVIDER_DIVZ_EN
      div_by_zero  <= 1'b0;
      divz_pending <= 1'b0;
`endif
    end else if (accept) begin
      dvd_q <= dividend;
      dvs   <= divisor;
      rem   <= '0;
      count <= CNT_W'(WIDTH);
      done  <= 1'b0;
`ifdef RESTORING_DIVIDER_DIVZ_EN
      div_by_zero <= 1'b0;
      if (divisor == '0) begin
        state        <= DONE;
        busy         <= 1'b0;
        divz_pending <= 1'b1;
      end else begin
        state <= RUN;
        busy  <= 1'b1;
      end
`else
      state <= RUN;
      busy  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
        end
        RUN: begin
          rem   <= rem_next;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {dvd_q[WIDTH-2:0], q_bit};
            remainder <= rem_next;
          end
        end
        DONE: begin
`ifdef RESTORING_DIVIDER_DIVZ_EN
          if (divz_pending) begin
            divz_pending <= 1'b0;
            done         <= 1'b1;
            div_by_zero  <= 1'b1;
            quotient     <= '1;
            remainder    <= dvd_q;
          end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            state       <= IDLE;
          end
`else
          done  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed timing steps plus a
// scoreboard of expected results compared whenever done pulses.
module tb_restoring_divider;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
`ifdef RESTORING_DIVIDER_DIVZ_EN
      e.dz = 1'b1;
`else
      e.dz = 1'b0;
`endif
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive one start for a single edge, then scramble the operand inputs.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    cycle();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    checkOutput(tag, done, 1'b1);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy_done_overlap", busy & done, 1'b0);
      checkOutput("done_width", prev_done & done, 1'b0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", done, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_quotient", quotient, mon_e.q);
          checkOutput("sb_remainder", remainder, mon_e.r);
          checkOutput("sb_div_by_zero", div_by_zero, mon_e.dz);
        end
      end
    end
    prev_done = done;
  end

  initial begin
    // Reset values
    cycle();
    cycle();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_dbz", div_by_zero, 1'b0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    rst_n = 1'b1;
    cycle();

    // 13/3: busy from edge k, done at k+4, done low at k+5
    applyStimulus(4'd13, 4'd3);
    checkOutput("t1_busy_k", busy, 1'b1);
    checkOutput("t1_done_k", done, 1'b0);
    repeat (3) cycle();
    checkOutput("t1_busy_k3", busy, 1'b1);
    checkOutput("t1_done_k3", done, 1'b0);
    cycle();
    checkOutput("t1_done_k4", done, 1'b1);
    checkOutput("t1_busy_k4", busy, 1'b0);
    checkOutput("t1_quotient", quotient, 4);
    checkOutput("t1_remainder", remainder, 1);
    cycle();
    checkOutput("t1_done_k5", done, 1'b0);
    checkOutput("t1_busy_k5", busy, 1'b0);

    // 15/1 then 2/15 with start held high throughout
    dividend = 4'd15;
    divisor  = 4'd1;
    start    = 1'b1;
    sb.push_back(model(4'd15, 4'd1));
    cycle();
    dividend = 4'd2;
    divisor  = 4'd15;
    sb.push_back(model(4'd2, 4'd15));
    repeat (3) cycle();
    checkOutput("t2_busy_k3", busy, 1'b1);
    cycle();
    checkOutput("t2_done_k4", done, 1'b1);
    checkOutput("t2_busy_k4", busy, 1'b0);
    checkOutput("t2_quotient_a", quotient, 15);
    checkOutput("t2_remainder_a", remainder, 0);
    cycle();
    checkOutput("t2_accept_k5", busy, 1'b1);
    checkOutput("t2_done_k5", done, 1'b0);
    start = 1'b0;
    repeat (3) cycle();
    checkOutput("t2_busy_k8", busy, 1'b1);
    cycle();
    checkOutput("t2_done_k9", done, 1'b1);
    checkOutput("t2_quotient_b", quotient, 0);
    checkOutput("t2_remainder_b", remainder, 2);
    cycle();

    // 9/0
    applyStimulus(4'd9, 4'd0);
`ifdef RESTORING_DIVIDER_DIVZ_EN
    checkOutput("t3_busy_k", busy, 1'b0);
    checkOutput("t3_done_k", done, 1'b0);
    cycle();
    checkOutput("t3_done_k1", done, 1'b1);
    checkOutput("t3_dbz_k1", div_by_zero, 1'b1);
    checkOutput("t3_busy_k1", busy, 1'b0);
`else
    checkOutput("t3_busy_k", busy, 1'b1);
    repeat (3) cycle();
    checkOutput("t3_done_k3", done, 1'b0);
    cycle();
    checkOutput("t3_done_k4", done, 1'b1);
    checkOutput("t3_dbz_k4", div_by_zero, 1'b0);
`endif
    checkOutput("t3_quotient", quotient, 15);
    checkOutput("t3_remainder", remainder, 9);
    cycle();
    checkOutput("t3_done_clear", done, 1'b0);
    checkOutput("t3_dbz_clear", div_by_zero, 1'b0);

    // 7/2 with a stray start pulse (operands 1/1) during RUN
    applyStimulus(4'd7, 4'd2);
    cycle();
    dividend = 4'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    checkOutput("t4_busy_k2", busy, 1'b1);
    cycle();
    cycle();
    checkOutput("t4_done_k4", done, 1'b1);
    checkOutput("t4_quotient", quotient, 3);
    checkOutput("t4_remainder", remainder, 1);
    cycle();
    cycle();
    checkOutput("t4_no_extra_done", done, 1'b0);
    checkOutput("t4_idle_busy", busy, 1'b0);

    // 12/5 aborted by reset just before edge k+2
    applyStimulus(4'd12, 4'd5);
    cycle();
    #7;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_busy", busy, 1'b0);
    checkOutput("t5_rst_done", done, 1'b0);
    checkOutput("t5_rst_quotient", quotient, 0);
    checkOutput("t5_rst_remainder", remainder, 0);
    checkOutput("t5_rst_dbz", div_by_zero, 1'b0);
    sb.delete();
    cycle();
    cycle();
    checkOutput("t5_held_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (6) cycle();
    checkOutput("t5_no_done_after", done, 1'b0);
    applyStimulus(4'd12, 4'd5);
    waitDone("t5_retry_done", W + 2);
    checkOutput("t5_quotient", quotient, 2);
    checkOutput("t5_remainder", remainder, 2);
    cycle();

    // Full sweep of non-zero divisors, back-to-back at full throughput
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(W'(a), W'(b));
        waitDone("sweep_done", W + 2);
      end
    end
    cycle();
    cycle();
    checkOutput("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
